// File: rtl/fpu_shift_pkg.sv
// Shared definitions for the pipelined FPU alignment shifter.
// Mode encodings and pipeline-depth helper.
package fpu_shift_pkg;

    localparam logic [1:0] MODE_SRL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_SLL = 2'b10;

    function automatic int calc_lat(input int shw, input int reg_every);
        return (shw + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational shifter level: shifts by DIST when enabled.
// Right shifts report the OR of the bits they drop.
module shift_level
    import fpu_shift_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_mode,
    input  logic             i_fill,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_data,
    output logic             o_drop
);

    logic             w_left;
    logic [WIDTH-1:0] w_rsh;
    logic [WIDTH-1:0] w_lsh;
    logic             w_lost;

    assign w_left = (i_mode == MODE_SLL);

    // A level wider than the word clears it entirely: no wrap-around.
    generate
        if (DIST >= WIDTH) begin : g_far
            assign w_rsh  = {WIDTH{i_fill}};
            assign w_lsh  = '0;
            assign w_lost = |i_data;
        end else begin : g_near
            assign w_rsh  = {{DIST{i_fill}}, i_data[WIDTH-1:DIST]};
            assign w_lsh  = {i_data[WIDTH-1-DIST:0], {DIST{1'b0}}};
            assign w_lost = |i_data[DIST-1:0];
        end
    endgenerate

    always_comb begin
        o_data = i_data;
        o_drop = 1'b0;
        if (i_en) begin
            if (w_left) begin
                o_data = w_lsh;
            end else begin
                o_data = w_rsh;
                o_drop = w_lost;
            end
        end
    end

endmodule

// File: rtl/align_shift_pipe.sv
// Pipelined barrel shifter (SRL/SRA/SLL) with sticky output
// and a valid/ready handshake with full backpressure.
module align_shift_pipe
    import fpu_shift_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int SHW       = 5,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L = calc_lat(SHW, REG_EVERY);

    logic [L-1:0]     r_valid;
    logic [WIDTH-1:0] r_data   [L];
    logic [SHW-1:0]   r_shamt  [L];
    logic [1:0]       r_mode   [L];
    logic [L-1:0]     r_fill;
    logic [L-1:0]     r_sticky;
    logic [TAG_W-1:0] r_tag    [L];

    logic [L-1:0]     w_cx_valid;
    logic [WIDTH-1:0] w_cx_data  [L];
    logic [SHW-1:0]   w_cx_shamt [L];
    logic [1:0]       w_cx_mode  [L];
    logic [L-1:0]     w_cx_fill;
    logic [L-1:0]     w_cx_sticky;
    logic [TAG_W-1:0] w_cx_tag   [L];

    logic [WIDTH-1:0] w_st_data  [L];
    logic [L-1:0]     w_st_sticky;
    logic [L:0]       w_adv;
    logic             w_unused;

    // Stage-input context: stage 0 sees the port, later stages the previous register.
    for (genvar s = 0; s < L; s++) begin : g_stg
        if (s == 0) begin : g_in
            assign w_cx_valid[0]  = in_valid;
            assign w_cx_data[0]   = in_data;
            assign w_cx_shamt[0]  = in_shamt;
            assign w_cx_mode[0]   = in_mode;
            assign w_cx_fill[0]   = (in_mode == MODE_SRA) & in_data[WIDTH-1];
            assign w_cx_sticky[0] = 1'b0;
            assign w_cx_tag[0]    = in_tag;
        end else begin : g_reg
            assign w_cx_valid[s]  = r_valid[s-1];
            assign w_cx_data[s]   = r_data[s-1];
            assign w_cx_shamt[s]  = r_shamt[s-1];
            assign w_cx_mode[s]   = r_mode[s-1];
            assign w_cx_fill[s]   = r_fill[s-1];
            assign w_cx_sticky[s] = r_sticky[s-1];
            assign w_cx_tag[s]    = r_tag[s-1];
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_lvl
        localparam int S = k / REG_EVERY;

        logic [WIDTH-1:0] w_i_data;
        logic [WIDTH-1:0] w_o_data;
        logic             w_i_sticky;
        logic             w_o_sticky;
        logic             w_drop;

        if (k % REG_EVERY == 0) begin : g_head
            assign w_i_data   = w_cx_data[S];
            assign w_i_sticky = w_cx_sticky[S];
        end else begin : g_body
            assign w_i_data   = g_lvl[k-1].w_o_data;
            assign w_i_sticky = g_lvl[k-1].w_o_sticky;
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_lvl (
            .i_data (w_i_data),
            .i_mode (w_cx_mode[S]),
            .i_fill (w_cx_fill[S]),
            .i_en   (w_cx_shamt[S][k]),
            .o_data (w_o_data),
            .o_drop (w_drop)
        );

        assign w_o_sticky = w_i_sticky | w_drop;

        if ((k % REG_EVERY == REG_EVERY - 1) || (k == SHW - 1)) begin : g_tail
            assign w_st_data[S]   = w_o_data;
            assign w_st_sticky[S] = w_o_sticky;
        end
    end

    // A stage moves when it is empty or its successor moves.
    always_comb begin
        w_adv    = '0;
        w_adv[L] = out_ready;
        for (int s = L - 1; s >= 0; s--) begin
            w_adv[s] = ~r_valid[s] | w_adv[s+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_fill   <= '0;
            r_sticky <= '0;
            for (int s = 0; s < L; s++) begin
                r_data[s]  <= '0;
                r_shamt[s] <= '0;
                r_mode[s]  <= '0;
                r_tag[s]   <= '0;
            end
        end else begin
            for (int s = 0; s < L; s++) begin
                if (w_adv[s]) begin
                    r_valid[s]  <= w_cx_valid[s];
                    r_data[s]   <= w_st_data[s];
                    r_shamt[s]  <= w_cx_shamt[s];
                    r_mode[s]   <= w_cx_mode[s];
                    r_fill[s]   <= w_cx_fill[s];
                    r_sticky[s] <= w_st_sticky[s];
                    r_tag[s]    <= w_cx_tag[s];
                end
            end
        end
    end

    // The final stage's control context has no consumer.
    assign w_unused = ^{r_shamt[L-1], r_mode[L-1], r_fill[L-1]};

    assign in_ready   = w_adv[0];
    assign out_valid  = r_valid[L-1];
    assign out_data   = r_data[L-1];
    assign out_sticky = r_sticky[L-1];
    assign out_tag    = r_tag[L-1];

endmodule

// File: tb/tb_align_shift_pipe.sv
// Scoreboard bench for align_shift_pipe with an arithmetic reference model.
// Driver pushes expectations on accept; monitor pops on each emitted beat.
module tb_align_shift_pipe;
    import fpu_shift_pkg::*;

    localparam int W  = 24;
    localparam int SH = 5;
    localparam int TW = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data   = '0;
    logic [SH-1:0] in_shamt  = '0;
    logic [1:0]    in_mode   = '0;
    logic [TW-1:0] in_tag    = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_sticky;
    logic [TW-1:0] out_tag;

    typedef struct packed {
        logic [W-1:0]  data;
        logic          sticky;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int vec = 0;
    int mis = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int out_cnt = 0;
    int out_cyc = 0;
    int stall_acc = -1;

    align_shift_pipe #(
        .WIDTH(W), .SHW(SH), .REG_EVERY(2), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sticky(out_sticky),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer shifts on a 64-bit sign/zero-extended copy.
    function automatic exp_t model(input logic [W-1:0] d, input int sh,
                                   input logic [1:0] m, input logic [TW-1:0] t);
        logic [63:0] x, mask, base, lost;
        exp_t e;
        mask  = (64'd1 << W) - 64'd1;
        x     = 64'(d);
        e.tag = t;
        if (m == MODE_SLL) begin
            e.data   = W'(x << sh);
            e.sticky = 1'b0;
        end else begin
            lost     = x & ((64'd1 << sh) - 64'd1);
            e.sticky = (lost != 64'd0);
            base     = (m == MODE_SRA && d[W-1]) ? (x | ~mask) : x;
            e.data   = W'(base >> sh);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #4;
        if (out_valid && out_ready) begin
            out_cnt++;
            out_cyc = cyc;
            if (q.size() == 0) begin
                vec++;
                mis++;
                $display("FAIL unexpected_output: got tag %0d expected none", out_tag);
            end else begin
                mon_e = q.pop_front();
                chk("out_data", 64'(out_data), 64'(mon_e.data));
                chk("out_sticky", 64'(out_sticky), 64'(mon_e.sticky));
                chk("out_tag", 64'(out_tag), 64'(mon_e.tag));
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input int sh,
                        input logic [1:0] m, input logic [TW-1:0] t);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = SH'(sh);
        in_mode  = m;
        in_tag   = t;
        #4;
        while (!in_ready && guard < 50) begin
            if (stall_acc < 0) stall_acc = acc_cnt;
            @(negedge clk);
            #4;
            guard++;
        end
        if (!in_ready) begin
            vec++;
            mis++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 (tag %0d)", t);
        end else begin
            q.push_back(model(d, sh, m, t));
            acc_cnt++;
            acc_cyc = cyc;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int oc;
        int g;
        int first;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sticky", 64'(out_sticky), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        oc = out_cnt;
        send(24'h800001, 1, MODE_SRL, 4'd3);
        idle();
        g = 0;
        while (out_cnt == oc && g < 20) begin
            @(posedge clk);
            g++;
        end
        chk("latency", 64'(out_cyc - acc_cyc), 64'd3);
        drain();

        send(24'h800010, 4, MODE_SRA, 4'd1);
        send(24'h800010, 31, MODE_SRA, 4'd2);
        send(24'h000003, 22, MODE_SLL, 4'd4);
        send(24'h000001, 24, MODE_SRL, 4'd5);
        send(24'hABCDEF, 8, 2'b11, 4'd6);
        send(24'h7FFFFF, 31, MODE_SRA, 4'd7);
        idle();
        drain();

        out_ready = 1'b0;
        stall_acc = -1;
        acc_cnt   = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(W'($urandom()), $urandom_range(0, 31),
                         2'($urandom_range(0, 3)), TW'(i));
                idle();
            end
            begin
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_accepts_before_stall", 64'(stall_acc), 64'd3);

        stall_acc = -1;
        oc        = out_cnt;
        first     = 0;
        for (int i = 0; i < 100; i++) begin
            send(W'($urandom()), $urandom_range(0, 31),
                 2'($urandom_range(0, 3)), TW'(i));
            if (i == 0) first = acc_cyc;
        end
        idle();
        drain();
        chk("tput_count", 64'(out_cnt - oc), 64'd100);
        chk("tput_span", 64'(out_cyc - first), 64'd102);
        chk("tput_no_stall", 64'(stall_acc < 0), 64'd1);

        send(24'h123456, 3, MODE_SRL, 4'd9);
        send(24'h654321, 5, MODE_SRA, 4'd10);
        idle();
        @(negedge clk);
        #1;
        chk("inflight_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data", 64'(out_data), 64'd0);
        q.delete();
        oc = out_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #5;
        chk("no_emit_after_reset", 64'(out_cnt - oc), 64'd0);

        send(24'hFFFFFF, 0, MODE_SRA, 4'd11);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule

// File: doc/align_shift_pipe.md
Name: align_shift_pipe

Overview:
- Parametrised, pipelined successor to the FPU's single-cycle 23-bit right shifter.
- Supports logical-right, arithmetic-right and logical-left modes over a configurable width.
- Produces the sticky (OR of shifted-out bits) needed for IEEE rounding during exponent alignment and normalisation.
- Sits between exponent compare and the mantissa adder, and after the adder in the normaliser, behind a valid/ready handshake with full backpressure.

Parameters:
- WIDTH, 24, data width in bits (mantissa including hidden bit); 2 to 64.
- SHW, 5, shift-amount width; must satisfy 2^SHW >= WIDTH.
- REG_EVERY, 2, number of mux levels between pipeline registers; 1 to SHW.
- TAG_W, 4, width of sideband tag carried alongside data unchanged.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage 0 can accept a beat
- in_data  in  WIDTH  operand
- in_shamt  in  SHW  shift amount, unsigned
- in_mode  in  2  00 SRL, 01 SRA, 10 SLL, 11 reserved (treated as SRL)
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  shifted result
- out_sticky  out  1  OR of all bits shifted out; 0 for SLL
- out_tag  out  TAG_W  tag of the matching input beat

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0, every stage valid=0, out_valid=0, out_data=0, out_sticky=0, out_tag=0.
- Reset mid-operation discards all in-flight beats; in_ready=1 from the first edge after release.
- Structure: SHW mux levels. Level k shifts by 2^k when shamt[k]=1. Levels are processed LSB first.
- Register boundaries: a register follows levels REG_EVERY-1, 2*REG_EVERY-1, ..., and always the final level.
- Latency: L = ceil(SHW/REG_EVERY) cycles from accept to out_valid when there is no stall. Default L=3.
- Fill values: SRL fills with 0. SRA fills with in_data[WIDTH-1], captured at accept and carried through the stages. SLL fills with 0.
- Sticky: each right-shift level ORs the bits it drops into a per-beat sticky flag, which is carried through the stages. SLL forces sticky=0.
- Over-range: if shamt >= WIDTH, the result is all-zero (SRL/SLL) or all-sign (SRA), and sticky = OR of in_data (right modes). This is handled naturally by the per-level fills; no special-case compare is needed, and no wrap-around occurs.
- Handshake: a beat is accepted when in_valid && in_ready, and leaves when out_valid && out_ready.
- Per-stage advance: a stage advances when it is empty or the stage after it advances. in_ready = stage-0 advance condition. Full throughput of 1 beat/cycle is required with out_ready held high.
- Stall: with out_ready=0, out_data, out_sticky and out_tag hold stable. Stages fill until in_ready=0, giving a maximum of L beats in flight. No beat is dropped or duplicated.
- Simultaneous accept and emit while full: both occur in the same cycle, and occupancy is unchanged.
- Payload registers load only on advance. Valid bits are the only control state.
- Out-of-order completion is impossible; beats exit in acceptance order with their tags.

Decomposition:
- Package fpu_shift_pkg holds the mode localparams (MODE_SRL, MODE_SRA, MODE_SLL) and a function computing L from SHW and REG_EVERY.
- Sub-module shift_level (parameters WIDTH, DIST) performs one combinational level: data, mode, fill bit and enable in; data and dropped-bit OR out.
- The top generates SHW instances plus the pipeline register and valid/advance logic.

Test Plan:
- Reset/latency (defaults): SRL of in_data=0x800001, shamt=1, tag=3 -> three cycles later out_data=0x400000, sticky=1, tag=3. All outputs are 0 during reset.
- SRA of in_data=0x800010, shamt=4 -> out_data=0xF80001, sticky=0. The same operand with shamt=31 -> 0xFFFFFF, sticky=1.
- SLL of in_data=0x000003, shamt=22 -> 0xC00000, sticky=0. SRL with shamt=24 on 0x000001 -> 0x000000, sticky=1.
- Backpressure: stream 6 beats with tags 0..5, holding out_ready=0 for 5 cycles. in_ready falls after 3 accepts. On release, tags exit 0..5 in order with correct data and no gaps or duplicates.
- Throughput: 100 back-to-back random beats with out_ready=1 -> 100 outputs in 102 cycles. A scoreboard matches a reference model for data and sticky.
- Reset asserted with 2 beats in flight -> out_valid drops asynchronously, and those beats are never emitted after release.
